// File: rtl/led_button_sequencer.sv
// led_button_sequencer: debounced buttons to LED toggle/running-light modes; RUN/PAUSE only with LED_SEQ_RUN_EN
module led_button_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STEP_CYCLES = 12500000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_btn_n,
  output logic [3:0] o_led_n,
  output logic [3:0] o_press,
  output logic [1:0] o_mode
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [3:0] sync1_q, sync2_q, stable_q, stable_d, press_q, press_d;
  logic [3:0] toggle_q, toggle_d, led_q, led_d;
  logic [DW-1:0] cnt_q [4];
  logic [DW-1:0] cnt_d [4];
  if (DEBOUNCE_CYCLES < 2 || STEP_CYCLES < 2) begin : g_bad_param
    $error("DEBOUNCE_CYCLES and STEP_CYCLES must be at least 2");
  end
  // accept a synchronized level once it has differed from the stable level long enough; falling accepts are presses
  always_comb begin
    stable_d = stable_q;
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != stable_q[k]) begin
        if (cnt_q[k] == DW'(DEBOUNCE_CYCLES)) stable_d[k] = sync2_q[k];
        else cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
    press_d = stable_q & ~stable_d;
  end
  // synchronizers, debounce state and registered press pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      press_q  <= '0;
      cnt_q    <= '{default: '0};
    end else begin
      sync1_q  <= i_btn_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end
`ifdef LED_SEQ_RUN_EN
  localparam int SW = $clog2(STEP_CYCLES);
  typedef enum logic [1:0] {TOGGLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} mode_e;
  mode_e mode_q, mode_d;
  logic [1:0] pos_q, pos_d;
  logic dir_q, dir_d, chord, step_tc;
  logic [SW-1:0] step_q, step_d;
  // mode transitions on the K1+K10 chord, running-light stepping, toggle updates and the next LED image
  always_comb begin
    chord = press_q[3] & ~stable_q[0];
    step_tc = step_q == SW'(STEP_CYCLES - 1);
    mode_d = mode_q;
    toggle_d = toggle_q;
    pos_d = pos_q;
    dir_d = dir_q;
    step_d = step_q;
    case (mode_q)
      TOGGLE: begin
        toggle_d = toggle_q ^ (press_q & {~chord, 3'b111});
        if (chord) begin
          mode_d = RUN;
          pos_d = '0;
          dir_d = 1'b0;
          step_d = '0;
        end
      end
      RUN: begin
        step_d = step_tc ? '0 : step_q + 1'b1;
        pos_d = step_tc ? (dir_q ? pos_q - 1'b1 : pos_q + 1'b1) : pos_q;
        dir_d = dir_q ^ press_q[1];
        mode_d = chord ? PAUSE : RUN;
      end
      default: mode_d = chord ? TOGGLE : PAUSE;
    endcase
    led_d = (mode_d == TOGGLE) ? ~toggle_d : ~(4'b0001 << pos_d);
  end
  // mode state and display registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q   <= TOGGLE;
      toggle_q <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      step_q   <= '0;
      led_q    <= '1;
    end else begin
      mode_q   <= mode_d;
      toggle_q <= toggle_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      led_q    <= led_d;
    end
  end
  assign o_mode = mode_q;
`else
  // every press toggles its own LED
  always_comb begin
    toggle_d = toggle_q ^ press_q;
    led_d = ~toggle_d;
  end
  // toggle pattern and display registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      toggle_q <= '0;
      led_q    <= '1;
    end else begin
      toggle_q <= toggle_d;
      led_q    <= led_d;
    end
  end
  assign o_mode = 2'b00;
`endif
  assign o_led_n = led_q;
  assign o_press = press_q;
endmodule

// File: tb/tb_led_button_sequencer.sv
// tb_led_button_sequencer: directed bench with a press-event scoreboard for led_button_sequencer
module tb_led_button_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] btn;
  logic [3:0] led, press;
  logic [1:0] mode;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int c, e, r;
  typedef struct {
    int cyc;
    logic [3:0] val;
  } exp_t;
  exp_t q[$];

  led_button_sequencer #(.DEBOUNCE_CYCLES(4), .STEP_CYCLES(8)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_btn_n(btn),
    .o_led_n(led),
    .o_press(press),
    .o_mode(mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic exp_press(input int at_cyc, input logic [3:0] v);
    q.push_back('{at_cyc, v});
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // scoreboard: every press pulse must match the next queued event in value and cycle
  always @(negedge clk) begin
    if (press !== 4'b0000) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL press_unexpected: observed %b expected none", press);
      end
      if (q.size() > 0) begin
        exp_t x;
        x = q.pop_front();
        chk("press_val", press, x.val);
        chk("press_cyc", cyc, x.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    btn = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_led", led, 4'hF);
    chk("rst_mode", mode, 2'b00);
    chk("rst_press", press, 4'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_led", led, 4'hF);
      chk("idle_mode", mode, 2'b00);
      chk("idle_press", press, 4'h0);
    end
    c = cyc; btn[2] = 1'b0; exp_press(c + 7, 4'b0100);
    at(c + 8); chk("b2_on", led, 4'b1011);
    btn[2] = 1'b1; at(c + 16);
    c = cyc; btn[2] = 1'b0; exp_press(c + 7, 4'b0100);
    at(c + 8); chk("b2_off", led, 4'b1111);
    btn[2] = 1'b1; at(c + 16);
    c = cyc; btn[0] = 1'b0;
    at(c + 3); btn[0] = 1'b1;
    at(c + 14); chk("glitch_led", led, 4'hF);
    c = cyc; btn[2:1] = 2'b00; exp_press(c + 7, 4'b0110);
    at(c + 8); chk("b12_led", led, 4'b1001);
    btn[2:1] = 2'b11; at(c + 16);
    c = cyc; btn[3] = 1'b0; exp_press(c + 7, 4'b1000);
    at(c + 8); chk("b3_on", led, 4'b0001); chk("b3_mode", mode, 2'b00);
    btn[3] = 1'b1; at(c + 16);
    c = cyc; btn[3] = 1'b0; exp_press(c + 7, 4'b1000);
    at(c + 8); chk("b3_off", led, 4'b1001);
    btn[3] = 1'b1; at(c + 16);
`ifdef LED_SEQ_RUN_EN
    c = cyc; btn[0] = 1'b0; exp_press(c + 7, 4'b0001);
    at(c + 8); chk("b0_led", led, 4'b1000);
    c = cyc; btn[3] = 1'b0; exp_press(c + 7, 4'b1000);
    at(c + 8); e = cyc;
    chk("run_mode", mode, 2'b01); chk("run_entry", led, 4'b1110);
    btn[3] = 1'b1; btn[0] = 1'b1;
    at(e + 8); chk("run_step1", led, 4'b1101);
    at(e + 16); chk("run_step2", led, 4'b1011);
    btn[1] = 1'b0; exp_press(e + 23, 4'b0010);
    at(e + 24); chk("run_step3", led, 4'b0111);
    btn[1] = 1'b1;
    at(e + 32); chk("run_down1", led, 4'b1011);
    at(e + 40); chk("run_down2", led, 4'b1101);
    btn[0] = 1'b0; exp_press(e + 47, 4'b0001);
    at(e + 42); btn[3] = 1'b0; exp_press(e + 49, 4'b1000);
    at(e + 50); chk("pause_mode", mode, 2'b10); chk("pause_led", led, 4'b1110);
    btn[3] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      at(e + 50 + 5 * i);
      chk("pause_hold", led, 4'b1110);
      chk("pause_hold_mode", mode, 2'b10);
    end
    btn[3] = 1'b0; exp_press(e + 82, 4'b1000);
    at(e + 83); chk("back_mode", mode, 2'b00); chk("back_led", led, 4'b1000);
    btn[3] = 1'b1;
    at(e + 91); btn[3] = 1'b0; exp_press(e + 98, 4'b1000);
    at(e + 99); chk("rerun_mode", mode, 2'b01); chk("rerun_led", led, 4'b1110);
    btn[3] = 1'b1;
    at(e + 103);
`else
    c = cyc; btn[0] = 1'b0; exp_press(c + 7, 4'b0001);
    at(c + 8); chk("b0_led", led, 4'b1000); chk("b0_mode", mode, 2'b00);
`endif
    r = cyc; rst = 1'b1;
    at(r + 1);
    chk("mid_rst_led", led, 4'hF);
    chk("mid_rst_mode", mode, 2'b00);
    chk("mid_rst_press", press, 4'h0);
    rst = 1'b0;
    c = cyc; exp_press(c + 7, 4'b0001);
    at(c + 8); chk("rearm_led", led, 4'b1110); chk("rearm_mode", mode, 2'b00);
    btn = 4'hF;
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_button_sequencer.md
# led_button_sequencer

Clocked controller between the four front-panel buttons (K1, K4, K7, K10, active-low) and LEDs L0–L3 (active-low). It synchronizes and debounces each button and turns presses into single-cycle events. A small mode state machine then uses those events to drive the LEDs as per-button toggles, a rotating running light, or a frozen display. It replaces the direct combinational button-to-LED path at board top level.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: cycles a synchronized level must stay stable before it is accepted (≥2).
- `STEP_CYCLES`, default 12500000: running-light step period in cycles (≥2).

- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_btn_n`  in  4  raw buttons; bit k is button k; 0 = pressed; asynchronous to `i_clk`.
- `o_led_n`  out  4  LED drive; bit k is Lk; 0 = lit; registered.
- `o_press`  out  4  one-cycle pulse per accepted press (debounced 1→0); registered.
- `o_mode`  out  2  current mode: 00 TOGGLE, 01 RUN, 10 PAUSE; 11 never driven.

## Operation
- Input stage, per button:
  - 2-FF synchronizer.
  - Debounce counter cleared whenever the synchronized value equals the stable level.
  - While they differ, the counter increments. When it reaches `DEBOUNCE_CYCLES`, the stable level takes the synchronized value and the counter clears.
- Press event: stable level 1→0. Raises `o_press[k]` for exactly one cycle. Release (0→1) raises no event.
- Chord: a press event on button 3 while the stable level of button 0 is 0 (held). It is consumed as the chord and does not act as a button-3 press.
- State registers:
  - `toggle_pat[3:0]` (1 = lit).
  - `pos[1:0]`.
  - `dir` (0 = up, 1 = down).
  - `step_cnt`.
- TOGGLE:
  - Each non-chord press k inverts `toggle_pat[k]`. Simultaneous presses all apply in the same cycle.
  - `o_led_n = ~toggle_pat`.
  - Chord → RUN, with `pos=0`, `dir=0`, `step_cnt=0`.
- RUN:
  - `o_led_n` has only bit `pos` low.
  - `step_cnt` counts 0..`STEP_CYCLES`-1. At the terminal count it wraps to 0 and `pos` moves one place (up: 3→0; down: 0→3).
  - Non-chord press on button 1 inverts `dir`. The change takes effect at the next step; `step_cnt` is not cleared. Other presses are ignored.
  - Chord → PAUSE.
- PAUSE:
  - `pos` and `step_cnt` are frozen; the LEDs hold the RUN pattern.
  - Non-chord presses are ignored.
  - Chord → TOGGLE.
- `toggle_pat` is preserved across RUN and PAUSE and is displayed again on return to TOGGLE.

## Timing
- Reset values: `o_led_n=4'b1111`, `o_press=4'b0000`, `o_mode=2'b00`.
- Internal reset values: synchronizers and stable levels 1, debounce counters 0, `toggle_pat=0`, `pos=0`, `dir=0`, `step_cnt=0`.
- Latency: a raw edge sampled at cycle t, held steady, gives `o_press` high at cycle t+2+`DEBOUNCE_CYCLES`. `o_led_n` and `o_mode` update one cycle after the `o_press` pulse.
- Bounce rejection: a level change that reverts within fewer than `DEBOUNCE_CYCLES` synchronized cycles produces no event.
- RUN entry: L0 lit one cycle after the chord pulse. The first advance comes `STEP_CYCLES` cycles after that.
- A chord press in the same cycle as a step terminal count: the mode change wins. In the PAUSE case, the step still applies in that cycle and the pattern then freezes.
- Reset asserted mid-operation, in any state, restores all reset values on the next edge. Any press in progress must be re-debounced from the released state.

## Configuration
- `LED_SEQ_RUN_EN` defined:
  - Full behaviour described above.
- `LED_SEQ_RUN_EN` undefined:
  - Chord detection, RUN/PAUSE states, `pos`, `dir` and `step_cnt` are compiled out.
  - Button 3 always toggles L3.
  - `o_mode` is constant 00.
  - `STEP_CYCLES` is unused.

## Test plan
Parameters: `DEBOUNCE_CYCLES=4`, `STEP_CYCLES=8`.
- Reset, buttons idle → `o_led_n=1111`, `o_mode=00`, `o_press=0000` on every cycle.
- Button 2 held low from cycle t → `o_press=0100` at t+6 for exactly one cycle; `o_led_n=1011` at t+7. A second press → `1111`.
- Button 0 glitches low for 3 cycles → no `o_press`; `o_led_n` unchanged.
- Chord sequence:
  - Press K1, then press K10 while K1 is held → `o_mode=01`, `o_led_n=1110`.
  - After 8 cycles → `1101`, then `1011`.
  - Button-1 press → direction reverses at the next step.
- Chord in RUN → `o_mode=10`, LEDs frozen for ≥20 cycles. Chord again → `o_mode=00`, with the prior `toggle_pat` restored.
- Assert `i_rst` for one cycle during RUN with a button held → all reset values. The held button is reported only after a fresh debounce (6 cycles after the release-and-press sequence).
